// File: rtl/spi_pkg.sv
// spi_pkg: types and constants shared by the SPI command parser.
// Latency: none (declarations only). Backpressure: none.
// Exports the FSM state type and codes, command-byte field layout and the MISO idle byte.
package spi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CMD   = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_READ  = 2'd3;

  localparam int         CMD_RW_BIT     = 7;
  localparam int         ADDR_W         = 7;
  localparam logic [7:0] MISO_IDLE_BYTE = 8'h00;

  // Byte counter that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_parser.sv
// spi_cmd_parser: turns SPI slave frames ({rw,addr} then data bytes) into register strobes.
// Latency: reg_wr/reg_rd 1 cycle after dval; spi_out_byte takes reg_rdata 2 cycles after dval.
// Backpressure: none; every dval is consumed, the SPI side sets the pace.
//
// Ports:
//   sys_clk, rst_n           clock and async active-low reset
//   spi_dat_recv[_dval/_fval] byte, byte strobe and frame-active from the SPI slave core
//   spi_out_byte             byte the slave core shifts out next on MISO
//   reg_addr/wdata/wr/rd     register-file access port; reg_rdata is valid 1 cycle after reg_rd
//   frame_done, frame_len    end-of-frame pulse and saturating byte count of that frame
module spi_cmd_parser
  import spi_pkg::*;
(
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [7:0]        spi_dat_recv,
  input  logic              spi_dat_recv_dval,
  input  logic              spi_dat_recv_fval,
  output logic [7:0]        spi_out_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  output logic              frame_done,
  output logic [7:0]        frame_len
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        byte_cnt;
  logic              fval_q;
  logic              rd_pend;
  logic              fval_rise;

  assign cmd_addr  = spi_dat_recv[ADDR_W-1:0];
  // fval_q resets high so a frame already in progress at reset release is
  // ignored until chip-select goes inactive and active again.
  assign fval_rise = spi_dat_recv_fval && !fval_q;

  // A byte arriving with fval already low is still handled; the frame closes
  // on the following cycle instead.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (fval_rise) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        if (spi_dat_recv_dval)
          state_nxt = spi_dat_recv[CMD_RW_BIT] ? ST_READ : ST_WRITE;
        else if (!spi_dat_recv_fval)
          state_nxt = ST_IDLE;
      end
      default: begin
        if (!spi_dat_recv_fval && !spi_dat_recv_dval) state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      addr         <= '0;
      byte_cnt     <= 8'd0;
      fval_q       <= 1'b1;
      rd_pend      <= 1'b0;
      spi_out_byte <= MISO_IDLE_BYTE;
      reg_addr     <= '0;
      reg_wdata    <= 8'd0;
      reg_wr       <= 1'b0;
      reg_rd       <= 1'b0;
      frame_done   <= 1'b0;
      frame_len    <= 8'd0;
    end else begin
      fval_q     <= spi_dat_recv_fval;
      state      <= state_nxt;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      frame_done <= 1'b0;
      // reg_rdata answers the read strobed last cycle.
      rd_pend    <= reg_rd;

      if (state == ST_IDLE) begin
        if (state_nxt == ST_CMD) byte_cnt <= 8'd0;
      end else if (spi_dat_recv_dval) begin
        byte_cnt <= sat_inc8(byte_cnt);
        case (state)
          ST_CMD: begin
            addr <= cmd_addr;
            if (spi_dat_recv[CMD_RW_BIT]) begin
              // First read fires straight off the command byte so its data
              // is ready by the time byte2 is shifted out.
              reg_rd   <= 1'b1;
              reg_addr <= cmd_addr;
              addr     <= cmd_addr + ADDR_ONE;
            end
          end
          ST_WRITE: begin
            reg_wr    <= 1'b1;
            reg_addr  <= addr;
            reg_wdata <= spi_dat_recv;
            addr      <= addr + ADDR_ONE;
          end
          ST_READ: begin
            reg_rd   <= 1'b1;
            reg_addr <= addr;
            addr     <= addr + ADDR_ONE;
          end
          default: ;
        endcase
      end else if (!spi_dat_recv_fval) begin
        frame_done <= 1'b1;
        frame_len  <= byte_cnt;
      end

      // Keyed off the next state so MISO is idle in the same cycle the FSM
      // leaves READ, even if a late read response is still arriving.
      if (state_nxt != ST_READ)
        spi_out_byte <= MISO_IDLE_BYTE;
      else if (rd_pend)
        spi_out_byte <= reg_rdata;
    end
  end

endmodule

// File: tb/tb_spi_cmd_parser.sv
module tb_spi_cmd_parser;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] spi_dat_recv = 8'd0;
  logic       spi_dat_recv_dval = 1'b0;
  logic       spi_dat_recv_fval = 1'b0;
  logic [7:0] spi_out_byte;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'd0;
  logic       frame_done;
  logic [7:0] frame_len;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  spi_cmd_parser dut (
    .sys_clk           (sys_clk),
    .rst_n             (rst_n),
    .spi_dat_recv      (spi_dat_recv),
    .spi_dat_recv_dval (spi_dat_recv_dval),
    .spi_dat_recv_fval (spi_dat_recv_fval),
    .spi_out_byte      (spi_out_byte),
    .reg_addr          (reg_addr),
    .reg_wdata         (reg_wdata),
    .reg_wr            (reg_wr),
    .reg_rd            (reg_rd),
    .reg_rdata         (reg_rdata),
    .frame_done        (frame_done),
    .frame_len         (frame_len)
  );

  // Register file contents returned on reads (writes are only logged).
  logic [7:0]  mem [128];
  logic        rd_seen = 1'b0;
  logic [6:0]  rd_seen_addr = 7'd0;

  int          cyc = 0;
  int          last_wr_cyc = -100;
  int          last_done_cyc = -100;
  int          both_hi = 0;
  logic [14:0] wr_log [$];
  logic [6:0]  rd_log [$];
  logic [7:0]  done_log [$];
  logic [7:0]  miso_log [$];
  logic [7:0]  fb [$];

  // Observe outputs mid-cycle; reg_rdata carries valid data only for the one
  // cycle after reg_rd, random garbage otherwise.
  always @(negedge sys_clk) begin
    cyc++;
    reg_rdata    = rd_seen ? mem[rd_seen_addr] : 8'($urandom);
    rd_seen      = reg_rd;
    rd_seen_addr = reg_addr;
    if (reg_wr) begin
      wr_log.push_back({reg_addr, reg_wdata});
      last_wr_cyc = cyc;
    end
    if (reg_rd) rd_log.push_back(reg_addr);
    if (reg_wr && reg_rd) both_hi++;
    if (frame_done) begin
      done_log.push_back(frame_len);
      last_done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    done_log.delete();
    miso_log.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit drop_fval);
    spi_dat_recv      = b;
    spi_dat_recv_dval = 1'b1;
    if (drop_fval) spi_dat_recv_fval = 1'b0;
    @(negedge sys_clk);
    spi_dat_recv_dval = 1'b0;
  endtask

  // MISO is sampled just before each byte starts shifting: once before the
  // command byte and once right after every dval.
  task automatic run_frame(input int gap, input bit coincide);
    @(negedge sys_clk);
    spi_dat_recv_fval = 1'b1;
    repeat (2) @(negedge sys_clk);
    miso_log.push_back(spi_out_byte);
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i], coincide && (i == fb.size() - 1));
      miso_log.push_back(spi_out_byte);
      repeat (gap) @(negedge sys_clk);
    end
    spi_dat_recv_fval = 1'b0;
    repeat (6) @(negedge sys_clk);
  endtask

  // Reference: derive expected strobes, MISO stream and length from the frame bytes.
  task automatic check_frame(input string tag, input bit coincide);
    int          n;
    bit          rw;
    logic [6:0]  a;
    logic [14:0] ew [$];
    logic [6:0]  er [$];
    logic [7:0]  em;
    int          exp_len;
    n  = fb.size();
    rw = 1'b0;
    a  = 7'd0;
    if (n > 0) begin
      rw = fb[0][7];
      a  = fb[0][6:0];
      if (rw) for (int i = 0; i < n; i++) er.push_back(7'(a + i));
      else    for (int i = 1; i < n; i++) ew.push_back({7'(a + i - 1), fb[i]});
    end
    exp_len = (n > 255) ? 255 : n;

    check({tag, "_done_cnt"}, done_log.size(), 1);
    if (done_log.size() > 0) check({tag, "_done_len"}, done_log[0], exp_len);
    check({tag, "_len_hold"}, frame_len, exp_len);
    check({tag, "_wr_cnt"}, wr_log.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wr_log.size(); i++)
      check({tag, "_wr"}, wr_log[i], ew[i]);
    check({tag, "_rd_cnt"}, rd_log.size(), er.size());
    for (int i = 0; i < er.size() && i < rd_log.size(); i++)
      check({tag, "_rd_addr"}, rd_log[i], er[i]);
    for (int j = 0; j < miso_log.size(); j++) begin
      em = (n > 0 && rw && j >= 2) ? mem[7'(a + j - 2)] : 8'h00;
      check({tag, "_miso"}, miso_log[j], em);
    end
    if (coincide && n > 1 && !rw)
      check({tag, "_done_after_wr"}, last_done_cyc - last_wr_cyc, 1);
    clear_logs();
  endtask

  initial begin
    int nb;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[3] = 8'hAA;
    mem[4] = 8'hBB;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_out_byte", spi_out_byte, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_strobes", {reg_wr, reg_rd, frame_done}, 0);
    check("rst_len", frame_len, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    clear_logs();

    // Basic write
    fb = '{8'h05, 8'h11, 8'h22};
    run_frame(3, 1'b0);
    check_frame("wr_basic", 1'b0);

    // Read with turnaround byte
    fb = '{8'h83, 8'h00, 8'h00, 8'h00};
    run_frame(3, 1'b0);
    check_frame("rd_basic", 1'b0);

    // Address wrap 127 -> 0
    fb = '{8'h7F, 8'h01, 8'h02};
    run_frame(4, 1'b0);
    check_frame("wr_wrap", 1'b0);

    // Empty frame
    fb.delete();
    run_frame(3, 1'b0);
    check_frame("empty", 1'b0);

    // Last byte arrives together with fval falling
    fb = '{8'h20, 8'h33, 8'h44};
    run_frame(3, 1'b1);
    check_frame("coinc", 1'b1);

    // Reset in the middle of a write frame
    @(negedge sys_clk);
    spi_dat_recv_fval = 1'b1;
    repeat (2) @(negedge sys_clk);
    send_byte(8'h10, 1'b0);
    repeat (3) @(negedge sys_clk);
    send_byte(8'h55, 1'b0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_byte", spi_out_byte, 0);
    check("midrst_addr", reg_addr, 0);
    check("midrst_wdata", reg_wdata, 0);
    check("midrst_strobes", {reg_wr, reg_rd, frame_done}, 0);
    check("midrst_len", frame_len, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    send_byte(8'h66, 1'b0);
    repeat (3) @(negedge sys_clk);
    send_byte(8'h77, 1'b0);
    repeat (3) @(negedge sys_clk);
    spi_dat_recv_fval = 1'b0;
    repeat (6) @(negedge sys_clk);
    check("midrst_wr_cnt", wr_log.size(), 1);
    if (wr_log.size() > 0) check("midrst_wr0", wr_log[0], {7'h10, 8'h55});
    check("midrst_done_cnt", done_log.size(), 0);
    check("midrst_rd_cnt", rd_log.size(), 0);
    clear_logs();
    fb = '{8'h85, 8'h00, 8'h00};
    run_frame(3, 1'b0);
    check_frame("post_rst", 1'b0);

    // Length saturation
    fb.delete();
    fb.push_back(8'h40);
    for (int i = 0; i < 259; i++) fb.push_back(8'($urandom));
    run_frame(3, 1'b0);
    check_frame("sat", 1'b0);

    // Random frames
    for (int f = 0; f < 25; f++) begin
      fb.delete();
      nb = $urandom_range(0, 7);
      for (int i = 0; i < nb; i++) fb.push_back(8'($urandom));
      run_frame($urandom_range(3, 5), 1'($urandom_range(0, 1)));
      check_frame("rand", 1'b0);
    end

    check("wr_rd_exclusive", both_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
